// File: rtl/c17v4_resp_misr.sv
// c17v4_resp_misr
// Response-capture stage behind the C17V4_Fritz combinational core. It folds the
// core outputs G6gat/G7gat into a multiple-input signature register (MISR) over
// NPAT valid patterns. It then compares the final signature with GOLDEN and
// reports the result to the BIST/scan controller.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (highest priority)
//   start      in   one-cycle pulse; begins a run from IDLE or DONE
//   resp_valid in   G6gat/G7gat carry a valid response this cycle
//   G6gat      in   core output, enters MISR bit 0
//   G7gat      in   core output, enters MISR bit 1
//   busy       out  run in progress
//   done       out  run complete; held until next start or reset
//   pass       out  final signature == GOLDEN; 0 whenever done is 0
//   signature  out  current MISR contents (W bits)
//   pat_count  out  patterns compacted so far in this run (CW bits)
//
// Handshake: a response is consumed on a rising edge where resp_valid=1 and the
// block is in RUN. There is no back-pressure. Responses offered in IDLE/DONE are
// dropped. A start in IDLE/DONE takes precedence over a response offered in the
// same cycle.
//
// The FSM state is kept in the named signal 'state' so that checkers can bind to it.

module c17v4_resp_misr #(
  parameter int             W      = 8,
  parameter logic [W-1:0]   POLY   = 8'h1D,
  parameter logic [W-1:0]   SEED   = 8'h00,
  parameter int             NPAT   = 32,
  parameter int             CW     = 16,
  parameter logic [W-1:0]   GOLDEN = 8'h00
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          resp_valid,
  input  logic          G6gat,
  input  logic          G7gat,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [W-1:0]  signature,
  output logic [CW-1:0] pat_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // pat_count value at which the next valid response is the last one.
  localparam logic [CW-1:0] LAST = CW'(NPAT - 1);

  // Shift left, fold the outgoing MSB back through the tap mask, then
  // inject the two core outputs into the low bits (all XOR, no carries).
  logic [W-1:0] sig_next;

  always_comb begin
    sig_next = {signature[W-2:0], 1'b0} ^ (signature[W-1] ? POLY : '0);
    sig_next = sig_next ^ {{(W-2){1'b0}}, G7gat, G6gat};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= SEED;
      pat_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Outputs in DONE stay frozen until the next start.
          // A response offered in the same cycle as start is not compacted.
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            signature <= SEED;
            pat_count <= '0;
          end
        end
        RUN: begin
          // start is deliberately ignored here; resp_valid=0 holds everything.
          if (resp_valid) begin
            signature <= sig_next;
            pat_count <= pat_count + CW'(1);
            if (pat_count == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              // Compare against the value being written, so pass is
              // valid in the same cycle that done first reads 1.
              pass  <= (sig_next == GOLDEN);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c17v4_resp_misr.sv
module tb_c17v4_resp_misr;

  localparam int NI = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic resp_valid;
  logic g6;
  logic g7;

  always #5 clk = ~clk;

  logic        busy_v [NI];
  logic        done_v [NI];
  logic        pass_v [NI];
  logic [7:0]  sig_v  [NI];
  logic [15:0] cnt_v  [NI];

  // Four configurations that share the same stimulus:
  // 0: SEED=00 NPAT=4  GOLDEN=00
  // 1: SEED=80 NPAT=1  GOLDEN=1E
  // 2: SEED=00 NPAT=2  GOLDEN=03
  // 3: SEED=00 NPAT=32 GOLDEN=00
  c17v4_resp_misr #(.W(8), .POLY(8'h1D), .SEED(8'h00), .NPAT(4), .CW(16), .GOLDEN(8'h00)) u_a (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .G6gat(g6), .G7gat(g7),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .signature(sig_v[0]), .pat_count(cnt_v[0]));
  c17v4_resp_misr #(.W(8), .POLY(8'h1D), .SEED(8'h80), .NPAT(1), .CW(16), .GOLDEN(8'h1E)) u_b (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .G6gat(g6), .G7gat(g7),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .signature(sig_v[1]), .pat_count(cnt_v[1]));
  c17v4_resp_misr #(.W(8), .POLY(8'h1D), .SEED(8'h00), .NPAT(2), .CW(16), .GOLDEN(8'h03)) u_c (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .G6gat(g6), .G7gat(g7),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .signature(sig_v[2]), .pat_count(cnt_v[2]));
  c17v4_resp_misr #(.W(8), .POLY(8'h1D), .SEED(8'h00), .NPAT(32), .CW(16), .GOLDEN(8'h00)) u_d (
    .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .G6gat(g6), .G7gat(g7),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .signature(sig_v[3]), .pat_count(cnt_v[3]));

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int seed_p   [NI] = '{8'h00, 8'h80, 8'h00, 8'h00};
  int npat_p   [NI] = '{4, 1, 2, 32};
  int golden_p [NI] = '{8'h00, 8'h1E, 8'h03, 8'h00};

  bit m_run  [NI];
  bit m_done [NI];
  bit m_pass [NI];
  int m_sig  [NI];
  int m_cnt  [NI];

  logic [7:0] exp_q[$];

  // Signature step as polynomial arithmetic: multiply by x, reduce by
  // x^8 + POLY, then add the two response bits.
  function automatic int misr_ref(int s, int b6, int b7);
    int v;
    v = s * 2;
    if (v >= 256) v = (v - 256) ^ 'h1D;
    return v ^ (b7 * 2 + b6);
  endfunction

  task automatic model_step(input logic r, input logic st, input logic rv,
                            input logic b6, input logic b7);
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        m_run[i] = 0; m_done[i] = 0; m_pass[i] = 0;
        m_sig[i] = seed_p[i]; m_cnt[i] = 0;
      end else if (!m_run[i] && st) begin
        m_run[i] = 1; m_done[i] = 0; m_pass[i] = 0;
        m_sig[i] = seed_p[i]; m_cnt[i] = 0;
      end else if (m_run[i] && rv) begin
        m_sig[i] = misr_ref(m_sig[i], int'(b6 === 1'b1), int'(b7 === 1'b1));
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == npat_p[i]) begin
          m_run[i] = 0; m_done[i] = 1;
          m_pass[i] = (m_sig[i] == golden_p[i]);
        end
      end
    end
  endtask

  function automatic logic [26:0] exp_vec(int i);
    return {m_run[i], m_done[i], m_pass[i], 8'(m_sig[i]), 16'(m_cnt[i])};
  endfunction

  function automatic logic [26:0] obs_vec(int i);
    return {busy_v[i], done_v[i], pass_v[i], sig_v[i], cnt_v[i]};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic st, input logic rv,
                       input logic b6, input logic b7);
    rst = r; start = st; resp_valid = rv; g6 = b6; g7 = b7;
    @(posedge clk);
    model_step(r, st, rv, b6, b7);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    drive(1, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      logic rv;
      rv = 1'($urandom_range(0, 1));
      drive(0, 0, rv, rv ? 1'($urandom_range(0, 1)) : 1'bx, rv ? 1'($urandom_range(0, 1)) : 1'bx);
      for (int i = 0; i < NI; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec(i)) begin
          bad++;
          $display("FAIL reset_idle inst%0d cyc%0d got=%h want=%h", i, c, obs_vec(i), exp_vec(i));
        end
      end
    end
    total++;
    if (obs_vec(3) !== 27'd0) begin
      bad++; $display("FAIL reset_values inst3 got=%h want=0", obs_vec(3));
    end
    total++;
    if (sig_v[1] !== 8'h80) begin
      bad++; $display("FAIL reset_seed inst1 got=%h want=80", sig_v[1]);
    end
  endtask

  task automatic test_basic;
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    total++;
    if (busy_v[2] !== 1'b1) begin
      bad++; $display("FAIL basic_busy got=%b want=1", busy_v[2]);
    end
    drive(0, 0, 1, 1, 0);
    total++;
    if (sig_v[2] !== 8'h01 || done_v[2] !== 1'b0) begin
      bad++; $display("FAIL basic_first got=%h/%b want=01/0", sig_v[2], done_v[2]);
    end
    drive(0, 0, 1, 1, 0);
    total++;
    if ({busy_v[2], done_v[2], pass_v[2], sig_v[2], cnt_v[2]} !== {1'b0, 1'b1, 1'b1, 8'h03, 16'd2}) begin
      bad++; $display("FAIL basic_done got=%h want=%h", obs_vec(2), {1'b0, 1'b1, 1'b1, 8'h03, 16'd2});
    end
  endtask

  task automatic test_feedback;
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    total++;
    if ({done_v[1], pass_v[1], sig_v[1], cnt_v[1]} !== {1'b1, 1'b0, 8'h1D, 16'd1}) begin
      bad++; $display("FAIL feedback_00 got=%b%b %h %h want=10 1d 0001", done_v[1], pass_v[1], sig_v[1], cnt_v[1]);
    end
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 1);
    total++;
    if ({done_v[1], pass_v[1], sig_v[1]} !== {1'b1, 1'b1, 8'h1E}) begin
      bad++; $display("FAIL feedback_11 got=%b%b %h want=11 1e", done_v[1], pass_v[1], sig_v[1]);
    end
  endtask

  task automatic test_stall;
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 0, 0);
      total++;
      if (sig_v[0] !== 8'h00 || cnt_v[0] !== 16'(k + 1)) begin
        bad++; $display("FAIL stall_valid k%0d got=%h/%0d want=00/%0d", k, sig_v[0], cnt_v[0], k + 1);
      end
      if (k < 3) begin
        if (k == 2) drive(0, 0, 0, 1'bx, 1'bx);
        else drive(0, (k == 1), 0, 1, 1);
        total++;
        if (sig_v[0] !== 8'h00 || cnt_v[0] !== 16'(k + 1) || busy_v[0] !== 1'b1) begin
          bad++; $display("FAIL stall_hold k%0d got=%h/%0d/%b want=00/%0d/1", k, sig_v[0], cnt_v[0], busy_v[0], k + 1);
        end
      end
    end
    total++;
    if ({busy_v[0], done_v[0], pass_v[0]} !== 3'b011) begin
      bad++; $display("FAIL stall_done got=%b want=011", {busy_v[0], done_v[0], pass_v[0]});
    end
    for (int c = 0; c < 3; c++) drive(0, 0, 1, 1, 1);
    total++;
    if ({done_v[0], sig_v[0], cnt_v[0]} !== {1'b1, 8'h00, 16'd4}) begin
      bad++; $display("FAIL done_frozen got=%b %h %0d want=1 00 4", done_v[0], sig_v[0], cnt_v[0]);
    end
  endtask

  task automatic test_restart;
    // inst0 and inst1 are in DONE after test_stall.
    drive(0, 1, 1, 1, 0);
    total++;
    if ({busy_v[0], done_v[0], pass_v[0], sig_v[0], cnt_v[0]} !== {1'b1, 1'b0, 1'b0, 8'h00, 16'd0}) begin
      bad++; $display("FAIL restart_a got=%h want=%h", obs_vec(0), {1'b1, 1'b0, 1'b0, 8'h00, 16'd0});
    end
    total++;
    if ({busy_v[1], done_v[1], pass_v[1], sig_v[1], cnt_v[1]} !== {1'b1, 1'b0, 1'b0, 8'h80, 16'd0}) begin
      bad++; $display("FAIL restart_b got=%h want=%h", obs_vec(1), {1'b1, 1'b0, 1'b0, 8'h80, 16'd0});
    end
  endtask

  task automatic test_random;
    drive(1, 0, 0, 0, 0);
    for (int c = 0; c < 400; c++) begin
      logic r, st, rv;
      r  = ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 11) == 0);
      rv = 1'($urandom_range(0, 1));
      drive(r, st, rv, rv ? 1'($urandom_range(0, 1)) : 1'bx, rv ? 1'($urandom_range(0, 1)) : 1'bx);
      for (int i = 0; i < NI; i++) begin
        total++;
        if (obs_vec(i) !== exp_vec(i)) begin
          bad++;
          $display("FAIL random inst%0d cyc%0d got=%h want=%h", i, c, obs_vec(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_reset_midrun;
    logic b6s [32];
    logic b7s [32];
    int   s;
    for (int k = 0; k < 32; k++) begin
      b6s[k] = 1'($urandom_range(0, 1));
      b7s[k] = 1'($urandom_range(0, 1));
    end
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 17; k++) drive(0, 0, 1, b6s[k], b7s[k]);
    total++;
    if (cnt_v[3] !== 16'd17) begin
      bad++; $display("FAIL midrun_count got=%0d want=17", cnt_v[3]);
    end
    drive(1, 0, 1, 1, 1);
    total++;
    if (obs_vec(3) !== 27'd0) begin
      bad++; $display("FAIL midrun_reset got=%h want=0", obs_vec(3));
    end
    s = 0;
    for (int k = 0; k < 32; k++) begin
      s = misr_ref(s, int'(b6s[k]), int'(b7s[k]));
      exp_q.push_back(8'(s));
    end
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 32; k++) begin
      logic [7:0] e;
      drive(0, 0, 1, b6s[k], b7s[k]);
      e = exp_q.pop_front();
      total++;
      if (sig_v[3] !== e) begin
        bad++; $display("FAIL midrun_sig step%0d got=%h want=%h", k, sig_v[3], e);
      end
    end
    total++;
    if ({busy_v[3], done_v[3], pass_v[3], cnt_v[3]} !== {1'b0, 1'b1, (s == 0), 16'd32}) begin
      bad++; $display("FAIL midrun_done got=%b%b%b %0d want=01%b 32", busy_v[3], done_v[3], pass_v[3], cnt_v[3], (s == 0));
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1; start = 1'b0; resp_valid = 1'b0; g6 = 1'b0; g7 = 1'b0;
    test_reset;
    test_basic;
    test_feedback;
    test_stall;
    test_restart;
    test_random;
    test_reset_midrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c17v4_resp_misr.md
Name: c17v4_resp_misr

Overview:
- Downstream response-capture stage for the C17V4_Fritz combinational core.
- Consumes G6gat/G7gat on each valid test pattern and compacts them into a multiple-input signature register (MISR) over a programmed number of patterns.
- At the end of the run, compares the signature against a golden value and reports pass/fail to the test controller.
- Sits between the core outputs and the BIST/scan controller.

Parameters:
- W, 8, MISR width in bits (W >= 3).
- POLY, 8'h1D, feedback tap mask: bit i set means the MISR MSB feeds bit i.
- SEED, 8'h00, MISR value loaded on start.
- NPAT, 32, patterns compacted per run (1 <= NPAT <= 2^CW-1).
- CW, 16, pattern counter width.
- GOLDEN, 8'h00, expected final signature.

Ports:
- clk  input  1  single clock; all flops rising-edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle pulse that begins a run.
- resp_valid  input  1  G6gat/G7gat carry a valid response this cycle.
- G6gat  input  1  core output G6gat.
- G7gat  input  1  core output G7gat.
- busy  output  1  run in progress.
- done  output  1  run complete; held until next start or reset.
- pass  output  1  final signature == GOLDEN; valid only while done=1, otherwise 0.
- signature  output  W  current MISR contents.
- pat_count  output  CW  patterns compacted so far in this run.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, pass=0, signature=SEED, pat_count=0. Reset has priority over every other input, including mid-run; no partial result survives.
- FSM states:
  - IDLE: start=1 loads signature=SEED, pat_count=0, enters RUN; busy=1 from the next cycle.
  - RUN: each cycle with resp_valid=1, the MISR updates and pat_count increments. When resp_valid=1 and pat_count==NPAT-1, the state moves to DONE on the same edge. resp_valid=0 holds all state. start in RUN is ignored.
  - DONE: busy=0, done=1, pass=(signature==GOLDEN), registered on entry. Signature and pat_count (=NPAT) are frozen and resp_valid is ignored. start=1 behaves exactly as in IDLE (clears done/pass, reseeds, enters RUN).
- MISR update, with s as the current value:
  - t = {s[W-2:0],1'b0} XOR (s[W-1] ? POLY : 0)
  - next = t XOR {{(W-2){1'b0}}, G7gat, G6gat}
  - G6gat enters bit0 and G7gat enters bit1. All arithmetic is modulo 2^W with no carries.
- Latency:
  - The response sampled at edge k appears in signature after edge k.
  - done rises the cycle after the edge that consumes the NPAT-th valid response; pass is valid in that same cycle.
- Boundary cases:
  - NPAT=1: first valid response moves RUN→DONE.
  - pat_count never wraps; it saturates at NPAT.
  - start and resp_valid in the same IDLE/DONE cycle: the start action wins and that response is NOT compacted.
  - X on G6gat/G7gat while resp_valid=0 must not affect state.

Test Plan:
- Reset then idle (W=8, SEED=0): rst 1 cycle, no start → busy=0, done=0, pass=0, signature=8'h00, pat_count=0 for 10 cycles regardless of resp_valid/G inputs.
- Basic compaction (SEED=0, NPAT=2): start, then valid (G6=1,G7=0), valid (G6=1,G7=0) → signature 8'h01 then 8'h03; done=1 the next cycle, pat_count=2; pass=1 iff GOLDEN=8'h03.
- Feedback path (SEED=8'h80, NPAT=1, POLY=8'h1D): start, valid (0,0) → signature=8'h1D, done=1; same with (1,1) → 8'h1E.
- Stall and ignore (SEED=0, NPAT=4): start, four valid (0,0) interleaved with resp_valid=0 cycles carrying G6=G7=1 → signature stays 8'h00, done after the 4th valid, pass=1 with GOLDEN=0. A start pulse mid-run does not reset pat_count.
- Restart from DONE: after a completed run (done=1), start with resp_valid=1, G6=1 → done=0, pass=0, signature=SEED, pat_count=0; that response is not compacted.
- Reset mid-run: NPAT=32, rst at pat_count=17 → all outputs return to reset values on the next edge; a subsequent full run gives the same signature as a run with no interruption.
